// File: rtl/mem_rmw_unit.sv
// -----------------------------------------------------------------------------
// mem_rmw_unit
//
// Data-memory unit for the BeeF processor. Owns the data array, the write-data
// source mux, the address mux and a registered result with a zero flag used
// for loop branching. Supports NOP, READ, WRITE (write-through to mem_out) and
// an in-place read-modify-write ADD used for cell increment/decrement.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  request present
//   req_ready  unit can accept a request this cycle (IDLE and not in reset)
//   mem_op     00 NOP, 01 READ, 10 WRITE, 11 ADD
//   mem_src    write data select: 0 acc_in, 1 alu_in, 2 save_in, 3 zero
//   mem_addr   address select: 0 head_in, 1 stack_in, 2 cache_in, 3 alu_in
//   acc_in     write-data candidate
//   alu_in     write-data candidate, also usable as an address
//   save_in    write-data candidate
//   head_in    address candidate
//   stack_in   address candidate
//   cache_in   address candidate
//   delta      signed two's-complement addend for ADD
//   rsp_valid  one-cycle pulse: mem_out/mem_zero were just updated
//   mem_out    registered result
//   mem_zero   registered (mem_out == 0)
//   busy       ADD in progress (modify/write-back cycle)
// -----------------------------------------------------------------------------
module mem_rmw_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_src,
  input  logic [1:0]        mem_addr,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] save_in,
  input  logic [ADDR_W-1:0] head_in,
  input  logic [ADDR_W-1:0] stack_in,
  input  logic [ADDR_W-1:0] cache_in,
  input  logic [DATA_W-1:0] delta,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_zero,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RMW_MOD = 1'b1
  } state_e;

  // alu_in used as an address: keep the low ADDR_W bits, zero-extending when
  // the address is wider than the data path.
  function automatic logic [ADDR_W-1:0] alu_to_addr(input logic [DATA_W-1:0] v);
    logic [ADDR_W+DATA_W-1:0] ext;
    ext = {{ADDR_W{1'b0}}, v};
    return ext[ADDR_W-1:0];
  endfunction

  // Data array (not cleared by reset).
  logic [DATA_W-1:0] mem_array_q [DEPTH];

  // Control and datapath registers.
  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] delta_q,   delta_d;
  logic [DATA_W-1:0] rd_buf_q,  rd_buf_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic              mem_zero_q, mem_zero_d;
  logic              rsp_valid_q, rsp_valid_d;

  // Combinational helpers.
  logic              accept_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_src_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] sum_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Handshake: only IDLE accepts, and never while reset is asserted.
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept_s  = req_valid && req_ready;

  // Address source mux.
  always_comb begin
    sel_addr_s = head_in;
    case (mem_addr)
      2'd0:    sel_addr_s = head_in;
      2'd1:    sel_addr_s = stack_in;
      2'd2:    sel_addr_s = cache_in;
      2'd3:    sel_addr_s = alu_to_addr(alu_in);
      default: sel_addr_s = head_in;
    endcase
  end

  // Write-data source mux.
  always_comb begin
    sel_src_s = {DATA_W{1'b0}};
    case (mem_src)
      2'd0:    sel_src_s = acc_in;
      2'd1:    sel_src_s = alu_in;
      2'd2:    sel_src_s = save_in;
      2'd3:    sel_src_s = {DATA_W{1'b0}};
      default: sel_src_s = {DATA_W{1'b0}};
    endcase
  end

  // Array read port; the value is only ever consumed into a register at the
  // accepting edge, so the array behaves as a synchronous-read memory.
  assign rd_data_s = mem_array_q[sel_addr_s];

  // Modular add: truncation to DATA_W gives the wrap-around, no carry kept.
  assign sum_s = rd_buf_q + delta_q;

  // FSM next state, array write control and result next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    delta_d     = delta_q;
    rd_buf_d    = rd_buf_q;
    mem_out_d   = mem_out_q;
    mem_zero_d  = mem_zero_q;
    rsp_valid_d = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = sel_addr_s;
    mem_wdata_s = sel_src_s;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (mem_op)
            OP_NOP: begin
              state_d = IDLE;
            end
            OP_READ: begin
              mem_out_d   = rd_data_s;
              mem_zero_d  = (rd_data_s == {DATA_W{1'b0}});
              rsp_valid_d = 1'b1;
            end
            OP_WRITE: begin
              mem_we_s    = 1'b1;
              mem_waddr_s = sel_addr_s;
              mem_wdata_s = sel_src_s;
              mem_out_d   = sel_src_s;
              mem_zero_d  = (sel_src_s == {DATA_W{1'b0}});
              rsp_valid_d = 1'b1;
            end
            OP_ADD: begin
              // mem_src is irrelevant here; only address and delta are kept.
              addr_d   = sel_addr_s;
              delta_d  = delta;
              rd_buf_d = rd_data_s;
              state_d  = RMW_MOD;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RMW_MOD: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = addr_q;
        mem_wdata_s = sum_s;
        mem_out_d   = sum_s;
        mem_zero_d  = (sum_s == {DATA_W{1'b0}});
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset edge must not disturb the array, including an ADD write-back.
    if (reset) begin
      mem_we_s = 1'b0;
    end else begin
      mem_we_s = mem_we_s;
    end
  end

  // Control/result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      delta_q     <= {DATA_W{1'b0}};
      rd_buf_q    <= {DATA_W{1'b0}};
      mem_out_q   <= {DATA_W{1'b0}};
      mem_zero_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      delta_q     <= delta_d;
      rd_buf_q    <= rd_buf_d;
      mem_out_q   <= mem_out_d;
      mem_zero_q  <= mem_zero_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_array_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign mem_out   = mem_out_q;
  assign mem_zero  = mem_zero_q;
  assign busy      = (state_q == RMW_MOD);

endmodule

// File: tb/tb_mem_rmw_unit.sv
module tb_mem_rmw_unit;
  localparam int DW = 8;
  localparam int AW = 8;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;
  localparam logic [1:0] ADD   = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    mem_op, mem_src, mem_addr;
  logic [DW-1:0] acc_in, alu_in, save_in, delta;
  logic [AW-1:0] head_in, stack_in, cache_in;
  logic          rsp_valid;
  logic [DW-1:0] mem_out;
  logic          mem_zero;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: array contents and last reported result.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_out;

  always #5 clk = ~clk;

  mem_rmw_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .mem_src(mem_src), .mem_addr(mem_addr),
    .acc_in(acc_in), .alu_in(alu_in), .save_in(save_in),
    .head_in(head_in), .stack_in(stack_in), .cache_in(cache_in),
    .delta(delta), .rsp_valid(rsp_valid), .mem_out(mem_out),
    .mem_zero(mem_zero), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_addr();
    case (mem_addr)
      2'd0:    return int'(head_in);
      2'd1:    return int'(stack_in);
      2'd2:    return int'(cache_in);
      default: return int'(alu_in);
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_src();
    case (mem_src)
      2'd0:    return acc_in;
      2'd1:    return alu_in;
      2'd2:    return save_in;
      default: return 8'h00;
    endcase
  endfunction

  task automatic rand_inputs();
    acc_in   = 8'($urandom);
    alu_in   = 8'($urandom);
    save_in  = 8'($urandom);
    head_in  = 8'($urandom);
    stack_in = 8'($urandom);
    cache_in = 8'($urandom);
    delta    = 8'($urandom);
    mem_src  = 2'($urandom);
    mem_addr = 2'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({req_ready, rsp_valid, busy, mem_zero, mem_out} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {req_ready, rsp_valid, busy, mem_zero, mem_out},
               {1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
    end
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; mem_op = WRITE; mem_src = 2'd0; acc_in = 8'h5A;
    mem_addr = 2'd0; head_in = 8'h10;
    tick();
    ref_mem[16] = 8'h5A;
    total++;
    if ({rsp_valid, busy, mem_zero, mem_out} !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL write_rsp got=%h exp=%h", {rsp_valid, busy, mem_zero, mem_out}, {1'b1, 1'b0, 1'b0, 8'h5A});
    end
    mem_op = READ; mem_addr = 2'd3; alu_in = 8'h10; acc_in = 8'h00; head_in = 8'h99;
    tick();
    total++;
    if ({rsp_valid, busy, mem_zero, mem_out} !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL read_alu_addr got=%h exp=%h", {rsp_valid, busy, mem_zero, mem_out}, {1'b1, 1'b0, 1'b0, 8'h5A});
    end
    req_valid = 1'b0;
    tick();
    total++;
    if ({rsp_valid, mem_out} !== {1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL idle_hold got=%h exp=%h", {rsp_valid, mem_out}, {1'b0, 8'h5A});
    end
  endtask

  task automatic test_add_wrap();
    req_valid = 1'b1; mem_op = WRITE; mem_src = 2'd2; save_in = 8'hFF;
    mem_addr = 2'd1; stack_in = 8'h20;
    tick();
    ref_mem[32] = 8'hFF;
    total++;
    if ({rsp_valid, mem_zero, mem_out} !== {1'b1, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL write_ff got=%h exp=%h", {rsp_valid, mem_zero, mem_out}, {1'b1, 1'b0, 8'hFF});
    end
    mem_op = ADD; delta = 8'h01; mem_src = 2'd3;
    tick();
    req_valid = 1'b0;
    total++;
    if ({req_ready, busy, rsp_valid} !== 3'b010) begin
      bad++;
      $display("FAIL add_busy got=%b exp=010", {req_ready, busy, rsp_valid});
    end
    tick();
    ref_mem[32] = 8'h00;
    total++;
    if ({req_ready, busy, rsp_valid, mem_zero, mem_out} !== {1'b1, 1'b0, 1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL add_wrap_up got=%h exp=%h", {req_ready, busy, rsp_valid, mem_zero, mem_out},
               {1'b1, 1'b0, 1'b1, 1'b1, 8'h00});
    end
    req_valid = 1'b1; mem_op = ADD; delta = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick();
    ref_mem[32] = 8'hFF;
    total++;
    if ({rsp_valid, mem_zero, mem_out} !== {1'b1, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL add_wrap_down got=%h exp=%h", {rsp_valid, mem_zero, mem_out}, {1'b1, 1'b0, 8'hFF});
    end
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; mem_op = ADD; delta = 8'h03; mem_addr = 2'd1; stack_in = 8'h20;
    tick();
    // READ held behind the ADD; must wait out the modify cycle.
    mem_op = READ; mem_addr = 2'd2; cache_in = 8'h20;
    total++;
    if ({req_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL bp_blocked got=%b exp=01", {req_ready, busy});
    end
    tick();
    ref_mem[32] = 8'h02;
    total++;
    if ({req_ready, busy, rsp_valid, mem_out} !== {1'b1, 1'b0, 1'b1, 8'h02}) begin
      bad++;
      $display("FAIL bp_add_rsp got=%h exp=%h", {req_ready, busy, rsp_valid, mem_out}, {1'b1, 1'b0, 1'b1, 8'h02});
    end
    tick();
    req_valid = 1'b0;
    total++;
    if ({rsp_valid, busy, mem_out} !== {1'b1, 1'b0, 8'h02}) begin
      bad++;
      $display("FAIL bp_read_rsp got=%h exp=%h", {rsp_valid, busy, mem_out}, {1'b1, 1'b0, 8'h02});
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_single_read got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_rmw();
    req_valid = 1'b1; mem_op = WRITE; mem_src = 2'd0; acc_in = 8'h07;
    mem_addr = 2'd0; head_in = 8'h30;
    tick();
    ref_mem[48] = 8'h07;
    mem_op = ADD; delta = 8'h01;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if ({rsp_valid, busy, mem_zero, mem_out} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL rmw_reset got=%h exp=%h", {rsp_valid, busy, mem_zero, mem_out}, {1'b0, 1'b0, 1'b1, 8'h00});
    end
    reset = 1'b0;
    req_valid = 1'b1; mem_op = READ; mem_addr = 2'd0; head_in = 8'h30;
    tick();
    req_valid = 1'b0;
    total++;
    if ({rsp_valid, mem_out} !== {1'b1, ref_mem[48]}) begin
      bad++;
      $display("FAIL rmw_abort_cell got=%h exp=%h", {rsp_valid, mem_out}, {1'b1, ref_mem[48]});
    end
  endtask

  task automatic test_zero_nop();
    req_valid = 1'b1; mem_op = WRITE; mem_src = 2'd3; acc_in = 8'hAA; alu_in = 8'hBB;
    save_in = 8'hCC; mem_addr = 2'd0; head_in = 8'h40;
    tick();
    ref_mem[64] = 8'h00;
    total++;
    if ({rsp_valid, mem_zero, mem_out} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL zero_src got=%h exp=%h", {rsp_valid, mem_zero, mem_out}, {1'b1, 1'b1, 8'h00});
    end
    mem_src = 2'd1; alu_in = 8'h33; head_in = 8'h41;
    tick();
    ref_mem[65] = 8'h33;
    mem_op = NOP; alu_in = 8'h77;
    tick();
    req_valid = 1'b0;
    total++;
    if ({req_ready, rsp_valid, mem_zero, mem_out} !== {1'b1, 1'b0, 1'b0, 8'h33}) begin
      bad++;
      $display("FAIL nop got=%h exp=%h", {req_ready, rsp_valid, mem_zero, mem_out}, {1'b1, 1'b0, 1'b0, 8'h33});
    end
  endtask

  task automatic test_random();
    int            a;
    logic [DW-1:0] s;
    logic [DW-1:0] d;
    // Give every cell a known value first.
    for (int i = 0; i < 256; i++) begin
      rand_inputs();
      req_valid = 1'b1; mem_op = WRITE; mem_addr = 2'd0; head_in = 8'(i);
      s = ref_src();
      tick();
      ref_mem[i] = s;
      ref_out = s;
      total++;
      if ({rsp_valid, mem_zero, mem_out} !== {1'b1, (s == 8'h00), s}) begin
        bad++;
        $display("FAIL fill[%0d] got=%h exp=%h", i, {rsp_valid, mem_zero, mem_out}, {1'b1, (s == 8'h00), s});
      end
    end
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      mem_op = 2'($urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      a = ref_addr();
      s = ref_src();
      d = delta;
      tick();
      if (req_valid && mem_op == ADD) begin
        total++;
        if ({req_ready, busy, rsp_valid} !== 3'b010) begin
          bad++;
          $display("FAIL rnd_add_busy[%0d] got=%b exp=010", n, {req_ready, busy, rsp_valid});
        end
        // Anything presented during the modify cycle must be ignored.
        rand_inputs();
        mem_op = 2'($urandom);
        req_valid = 1'($urandom);
        tick();
        ref_out = ref_mem[a] + d;
        ref_mem[a] = ref_out;
        total++;
        if ({rsp_valid, busy, mem_zero, mem_out} !== {1'b1, 1'b0, (ref_out == 8'h00), ref_out}) begin
          bad++;
          $display("FAIL rnd_add[%0d] got=%h exp=%h", n, {rsp_valid, busy, mem_zero, mem_out},
                   {1'b1, 1'b0, (ref_out == 8'h00), ref_out});
        end
      end else begin
        if (req_valid && mem_op == READ) begin
          ref_out = ref_mem[a];
        end else if (req_valid && mem_op == WRITE) begin
          ref_mem[a] = s;
          ref_out = s;
        end
        total++;
        if ({rsp_valid, busy, mem_zero, mem_out} !==
            {(req_valid && (mem_op == READ || mem_op == WRITE)), 1'b0, (ref_out == 8'h00), ref_out}) begin
          bad++;
          $display("FAIL rnd_op[%0d] op=%0d got=%h exp=%h", n, mem_op, {rsp_valid, busy, mem_zero, mem_out},
                   {(req_valid && (mem_op == READ || mem_op == WRITE)), 1'b0, (ref_out == 8'h00), ref_out});
        end
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; mem_op = NOP; mem_src = 2'd0; mem_addr = 2'd0;
    acc_in = 8'h00; alu_in = 8'h00; save_in = 8'h00; delta = 8'h00;
    head_in = 8'h00; stack_in = 8'h00; cache_in = 8'h00;
    ref_out = 8'h00;
    test_reset();
    test_write_read();
    test_add_wrap();
    test_backpressure();
    test_reset_mid_rmw();
    test_zero_nop();
    test_random();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_rmw_unit.md
# mem_rmw_unit

Parametrised data-memory unit for the BeeF processor with selectable data source, selectable address source, a request/response handshake, and an in-place read-modify-write (ADD) operation for cell increment/decrement. It sits between the decode/ALU stage and the data array. It owns the array, the source and address muxes, and a registered result with a zero flag that drives loop branching.

## Interface
Parameters:
- DATA_W, 8, cell width in bits
- ADDR_W, 8, address width; array depth is 2**ADDR_W cells

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- mem_op  in  2  00 NOP, 01 READ, 10 WRITE, 11 ADD
- mem_src  in  2  write data: 0 acc_in, 1 alu_in, 2 save_in, 3 constant zero
- mem_addr  in  2  address: 0 head_in, 1 stack_in, 2 cache_in, 3 alu_in
- acc_in, alu_in, save_in  in  DATA_W  write-data candidates
- head_in, stack_in, cache_in  in  ADDR_W  address candidates
- delta  in  DATA_W  signed two's-complement addend for ADD
- rsp_valid  out  1  one-cycle pulse: mem_out/mem_zero updated
- mem_out  out  DATA_W  registered result
- mem_zero  out  1  registered (mem_out == 0)
- busy  out  1  ADD in progress (state RMW_MOD)

## Operation
- Handshake: a request is accepted on an edge where req_valid && req_ready. mem_op, mem_src, mem_addr, all data and address inputs, and delta are sampled only at acceptance.
- req_ready = (state == IDLE) && !reset.
- Address mux: alu_in is used as an address via its low ADDR_W bits, zero-extended if ADDR_W > DATA_W.
- Array: single-port, synchronous read and write. Contents are not cleared by reset.
- FSM states: IDLE and RMW_MOD.
- IDLE, NOP accepted: no array access, no rsp_valid, stay IDLE.
- IDLE, READ accepted: mem_out <= array[addr], rsp_valid pulses, stay IDLE.
- IDLE, WRITE accepted: array[addr] <= src, mem_out <= src (write-through), rsp_valid pulses, stay IDLE.
- IDLE, ADD accepted: latch addr and delta, rd_buf <= array[addr], go to RMW_MOD.
- RMW_MOD (unconditional, one cycle):
  - sum = (rd_buf + delta) mod 2**DATA_W
  - array[addr] <= sum, mem_out <= sum, rsp_valid pulses, return to IDLE.
- ADD ignores mem_src.
- mem_zero updates on every rsp_valid edge, from the same value loaded into mem_out.
- Wrap-around: 0xFF + 0x01 = 0x00 and 0x00 + 0xFF = 0xFF (DATA_W=8). No carry or overflow flag.
- Reset in RMW_MOD: the pending write is aborted and the array is unchanged. State goes to IDLE.
- Reset outputs: mem_out = 0, mem_zero = 1, rsp_valid = 0, busy = 0. req_ready is 0 while reset is asserted and 1 in the first cycle after it is released.

## Timing
- READ and WRITE: accepted at edge E; rsp_valid high in cycle E+1; mem_out stable from E+1 until the next response.
- Throughput: READ and WRITE can be issued back-to-back every cycle.
- ADD: accepted at edge E; busy and !req_ready during cycle E+1; write and response at edge E+1; rsp_valid high in cycle E+2; next request accepted at edge E+2 at the earliest.
- Ordering: a WRITE at edge E followed by a READ at edge E+1 to the same address returns the new value. An ADD following a WRITE or ADD to the same address sees the updated cell. No forwarding logic is needed because the array is single-port and requests are serialised.
- While !req_ready, req_valid is ignored. The requester must hold its request until acceptance.
- No output depends combinationally on the inputs except req_ready, which depends on reset.

## Test plan
- Reset then idle: assert reset for 2 cycles -> mem_out=0, mem_zero=1, rsp_valid=0, busy=0, req_ready=0 during reset and 1 on the first cycle after.
- WRITE/READ and source/address select: WRITE src=acc_in=0x5A at addr=head_in=0x10, then READ mem_addr=3 with alu_in=0x10 -> both responses mem_out=0x5A, mem_zero=0, rsp_valid pulses in consecutive cycles.
- ADD wrap: cell 0x20 = 0xFF; ADD delta=0x01 -> busy one cycle, mem_out=0x00, mem_zero=1, rsp_valid at E+2. Then ADD delta=0xFF -> mem_out=0xFF.
- Backpressure during ADD: hold req_valid=1 with READ behind an ADD -> READ not accepted in the RMW_MOD cycle, accepted next, and returns the post-ADD value.
- Reset mid-RMW: cell 0x30 = 0x07; ADD delta=0x01, assert reset in the RMW_MOD cycle -> no rsp_valid; a subsequent READ of 0x30 returns 0x07.
- Zero source and NOP: WRITE mem_src=3 to 0x40 -> mem_out=0x00, mem_zero=1. A NOP request -> accepted, no rsp_valid, mem_out unchanged.
